// File: rtl/isp_frame_sequencer.sv
// Frame-level controller: runs Gaussian convolution then FAST per frame, with watchdogs, abort and error reporting.
// Optional build macro ISP_SEQ_PERF_CNT_EN adds a CONV_WAIT cycle counter reported on conv_cycles.
module isp_frame_sequencer #(
    parameter int X_MAX      = 200,
    parameter int Y_MAX      = 200,
    parameter int MAX_KERNEL = 3,
    parameter int TIMEOUT_W  = 20,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX),
    localparam int KW = $clog2(MAX_KERNEL)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [XW-1:0] cfg_max_x,
    input  logic [YW-1:0] cfg_max_y,
    input  logic [2:0]    cfg_sigma,
    input  logic [KW-1:0] cfg_kernel_size,
    input  logic          frame_start,
    input  logic          abort,
    input  logic          err_clr,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          conv_new_trans,
    input  logic          conv_done,
    output logic [XW-1:0] conv_max_x,
    output logic [YW-1:0] conv_max_y,
    output logic [2:0]    conv_sigma,
    output logic [KW-1:0] conv_kernel_size,
    output logic          fast_start,
    input  logic          fast_done,
    output logic          buf_sel,
    output logic [15:0]   frame_count,
    output logic [31:0]   conv_cycles
);

    typedef enum logic [2:0] {
        IDLE, CONV_START, CONV_WAIT, FAST_START, FAST_WAIT, DONE, ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CFG  = 2'd1;
    localparam logic [1:0] ERR_CONV = 2'd2;
    localparam logic [1:0] ERR_FAST = 2'd3;

    // Common width wide enough to compare extent against kernel_size-1
    localparam int LW = ((XW > YW) ? ((XW > KW) ? XW : KW) : ((YW > KW) ? YW : KW)) + 1;
    // Watchdog fires when the next increment would reach all-ones
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    state_t                state_reg, state_next;
    logic [1:0]            err_code_reg, err_code_next;
    logic [TIMEOUT_W-1:0]  wd_reg, wd_next;
    logic [XW-1:0]         max_x_reg;
    logic [YW-1:0]         max_y_reg;
    logic [2:0]            sigma_reg;
    logic [KW-1:0]         kernel_reg;
    logic                  buf_sel_reg;
    logic [15:0]           frame_count_reg;

    logic                  cfg_load;
    logic                  frame_commit;
    logic                  cfg_legal;
    logic [LW-1:0]         k_ext, k_minus1, x_ext, y_ext;

    assign k_ext    = LW'(kernel_reg);
    assign k_minus1 = k_ext - LW'(1);
    assign x_ext    = LW'(max_x_reg);
    assign y_ext    = LW'(max_y_reg);
    // Odd implies non-zero, so k_minus1 never underflows when the other terms matter
    assign cfg_legal = kernel_reg[0] && (k_ext <= LW'(MAX_KERNEL))
                       && (x_ext >= k_minus1) && (y_ext >= k_minus1);

    assign cfg_load     = cfg_valid && cfg_ready;
    assign frame_commit = (state_reg == DONE) && !abort;

    always_comb begin
        state_next     = state_reg;
        err_code_next  = err_code_reg;
        wd_next        = wd_reg;
        cfg_ready      = 1'b0;
        busy           = 1'b0;
        conv_new_trans = 1'b0;
        fast_start     = 1'b0;
        frame_done     = 1'b0;
        frame_err      = 1'b0;
        case (state_reg)
            IDLE: begin
                cfg_ready = 1'b1;
                if (frame_start && !cfg_valid) begin
                    if (cfg_legal) begin
                        state_next = CONV_START;
                    end else begin
                        state_next    = ERROR;
                        err_code_next = ERR_CFG;
                    end
                end
            end
            CONV_START: begin
                busy           = 1'b1;
                conv_new_trans = 1'b1;
                wd_next        = '0;
                state_next     = CONV_WAIT;
            end
            CONV_WAIT: begin
                busy = 1'b1;
                if (conv_done) begin
                    state_next = FAST_START;
                end else if (wd_reg == WD_LAST) begin
                    state_next    = ERROR;
                    err_code_next = ERR_CONV;
                end else begin
                    wd_next = wd_reg + TIMEOUT_W'(1);
                end
            end
            FAST_START: begin
                busy       = 1'b1;
                fast_start = 1'b1;
                wd_next    = '0;
                state_next = FAST_WAIT;
            end
            FAST_WAIT: begin
                busy = 1'b1;
                if (fast_done) begin
                    state_next = DONE;
                end else if (wd_reg == WD_LAST) begin
                    state_next    = ERROR;
                    err_code_next = ERR_FAST;
                end else begin
                    wd_next = wd_reg + TIMEOUT_W'(1);
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                frame_err = 1'b1;
                if (err_clr) begin
                    state_next    = IDLE;
                    err_code_next = ERR_NONE;
                end
            end
            default: begin
                state_next    = IDLE;
                err_code_next = ERR_NONE;
            end
        endcase
        // Abort beats done and timeout arriving in the same cycle
        if (busy && abort) begin
            state_next    = IDLE;
            err_code_next = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg       <= IDLE;
            err_code_reg    <= ERR_NONE;
            wd_reg          <= '0;
            max_x_reg       <= '0;
            max_y_reg       <= '0;
            sigma_reg       <= '0;
            kernel_reg      <= '0;
            buf_sel_reg     <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
            wd_reg       <= wd_next;
            if (cfg_load) begin
                max_x_reg  <= cfg_max_x;
                max_y_reg  <= cfg_max_y;
                sigma_reg  <= cfg_sigma;
                kernel_reg <= cfg_kernel_size;
            end
            if (frame_commit) begin
                buf_sel_reg     <= ~buf_sel_reg;
                frame_count_reg <= frame_count_reg + 16'd1;
            end
        end
    end

    assign err_code         = err_code_reg;
    assign conv_max_x       = max_x_reg;
    assign conv_max_y       = max_y_reg;
    assign conv_sigma       = sigma_reg;
    assign conv_kernel_size = kernel_reg;
    assign buf_sel          = buf_sel_reg;
    assign frame_count      = frame_count_reg;

`ifdef ISP_SEQ_PERF_CNT_EN
    logic [31:0] perf_cnt_reg;
    logic [31:0] conv_cycles_reg;
    logic [31:0] perf_inc;

    // Count includes the cycle conv_done arrives in
    assign perf_inc = (perf_cnt_reg == 32'hFFFF_FFFF) ? perf_cnt_reg : perf_cnt_reg + 32'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perf_cnt_reg    <= '0;
            conv_cycles_reg <= '0;
        end else if (state_reg == CONV_START) begin
            perf_cnt_reg <= '0;
        end else if (state_reg == CONV_WAIT) begin
            perf_cnt_reg <= perf_inc;
            if (conv_done && !abort) begin
                conv_cycles_reg <= perf_inc;
            end
        end
    end

    assign conv_cycles = conv_cycles_reg;
`else
    assign conv_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Randomized frame scenarios checked per cycle against a timeline model derived from the frame rules.
module tb_isp_frame_sequencer;
    localparam int TW    = 6;
    localparam int LIMIT = (1 << TW) - 1;
    localparam int XW    = $clog2(200);
    localparam int YW    = $clog2(200);
    localparam int KW    = $clog2(3);
    localparam int P_IDLE = 0, P_CS = 1, P_CW = 2, P_FS = 3, P_FW = 4, P_DONE = 5, P_ERR = 6;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          cfg_valid, cfg_ready;
    logic [XW-1:0] cfg_max_x;
    logic [YW-1:0] cfg_max_y;
    logic [2:0]    cfg_sigma;
    logic [KW-1:0] cfg_kernel_size;
    logic          frame_start, abort, err_clr;
    logic          busy, frame_done, frame_err;
    logic [1:0]    err_code;
    logic          conv_new_trans, conv_done, fast_start, fast_done;
    logic [XW-1:0] conv_max_x;
    logic [YW-1:0] conv_max_y;
    logic [2:0]    conv_sigma;
    logic [KW-1:0] conv_kernel_size;
    logic          buf_sel;
    logic [15:0]   frame_count;
    logic [31:0]   conv_cycles;

    isp_frame_sequencer #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .n_rst(n_rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_max_x(cfg_max_x), .cfg_max_y(cfg_max_y),
        .cfg_sigma(cfg_sigma), .cfg_kernel_size(cfg_kernel_size),
        .frame_start(frame_start), .abort(abort), .err_clr(err_clr),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
        .conv_new_trans(conv_new_trans), .conv_done(conv_done),
        .conv_max_x(conv_max_x), .conv_max_y(conv_max_y),
        .conv_sigma(conv_sigma), .conv_kernel_size(conv_kernel_size),
        .fast_start(fast_start), .fast_done(fast_done),
        .buf_sel(buf_sel), .frame_count(frame_count), .conv_cycles(conv_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted config, completed-frame bookkeeping
    logic [XW-1:0] m_mx;
    logic [YW-1:0] m_my;
    logic [2:0]    m_sig;
    logic [KW-1:0] m_k;
    logic [15:0]   m_count;
    logic          m_buf;
    logic [31:0]   m_cc;

    // Current frame scenario, times relative to the frame_start cycle (t=0)
    bit s_legal, s_abort_eff, s_noise;
    int s_c, s_f, s_ta, s_clr_t;

    function automatic bit legal(input int mx, input int my, input int k);
        return (k % 2 == 1) && (k >= 1) && (k <= 3) && (mx >= k - 1) && (my >= k - 1);
    endfunction

    function automatic bit is_busy(input int p);
        return (p >= P_CS) && (p <= P_DONE);
    endfunction

    function automatic int raw_phase(input int t);
        if (t <= 0) return P_IDLE;
        if (!s_legal) return P_ERR;
        if (t == 1) return P_CS;
        if (s_c > LIMIT) return (t <= 1 + LIMIT) ? P_CW : P_ERR;
        if (t <= 1 + s_c) return P_CW;
        if (t == 2 + s_c) return P_FS;
        if (s_f > LIMIT) return (t <= 2 + s_c + LIMIT) ? P_FW : P_ERR;
        if (t <= 2 + s_c + s_f) return P_FW;
        if (t == 3 + s_c + s_f) return P_DONE;
        return P_IDLE;
    endfunction

    function automatic int phase(input int t);
        int p;
        if (s_abort_eff && t > s_ta) return P_IDLE;
        p = raw_phase(t);
        if (p == P_ERR && s_clr_t >= 0 && t > s_clr_t) return P_IDLE;
        return p;
    endfunction

    task automatic check_cycle(input int ph, input logic [1:0] ec, input string tag);
        logic [7:0]  exp_ctl, got_ctl;
        logic [31:0] exp_cc;
        exp_ctl = {ph == P_IDLE, is_busy(ph), ph == P_CS, ph == P_FS, ph == P_DONE, ph == P_ERR,
                   (ph == P_ERR) ? ec : 2'd0};
        got_ctl = {cfg_ready, busy, conv_new_trans, fast_start, frame_done, frame_err, err_code};
        n_checks++;
        assert (got_ctl === exp_ctl) else begin
            n_fail++;
            $error("FAIL %s ctl{rdy,busy,cnt,fst,done,err,code} got=%b exp=%b", tag, got_ctl, exp_ctl);
        end
        n_checks++;
        assert ({conv_max_x, conv_max_y, conv_sigma, conv_kernel_size} === {m_mx, m_my, m_sig, m_k}) else begin
            n_fail++;
            $error("FAIL %s shadow got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", tag,
                   conv_max_x, conv_max_y, conv_sigma, conv_kernel_size, m_mx, m_my, m_sig, m_k);
        end
        n_checks++;
        assert ({frame_count, buf_sel} === {m_count, m_buf}) else begin
            n_fail++;
            $error("FAIL %s count/buf got=%0d/%0d exp=%0d/%0d", tag, frame_count, buf_sel, m_count, m_buf);
        end
`ifdef ISP_SEQ_PERF_CNT_EN
        exp_cc = m_cc;
`else
        exp_cc = 32'd0;
`endif
        n_checks++;
        assert (conv_cycles === exp_cc) else begin
            n_fail++;
            $error("FAIL %s conv_cycles got=%0d exp=%0d", tag, conv_cycles, exp_cc);
        end
    endtask

    task automatic drive(input int t, input int p);
        bit nz;
        nz = s_noise;
        cfg_max_x       = XW'($urandom);
        cfg_max_y       = YW'($urandom);
        cfg_sigma       = 3'($urandom);
        cfg_kernel_size = KW'($urandom);
        cfg_valid   = nz && (p != P_IDLE) && ($urandom_range(0, 7) == 0);
        frame_start = (t == 0) || (nz && (p != P_IDLE) && ($urandom_range(0, 7) == 0));
        conv_done   = (t == 1 + s_c && s_c <= LIMIT) || (nz && (p != P_CW) && ($urandom_range(0, 7) == 0));
        fast_done   = (t == 2 + s_c + s_f && s_c <= LIMIT && s_f <= LIMIT)
                      || (nz && (p != P_FW) && ($urandom_range(0, 7) == 0));
        abort       = (t == s_ta) || (nz && !is_busy(p) && ($urandom_range(0, 7) == 0));
        err_clr     = (t == s_clr_t) || (nz && (p != P_ERR) && ($urandom_range(0, 7) == 0));
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; frame_start = 1'b0; conv_done = 1'b0;
        fast_done = 1'b0; abort = 1'b0; err_clr = 1'b0;
    endtask

    task automatic load_cfg(input int mx, input int my, input int sig, input int k, input bit with_start);
        @(negedge clk);
        check_cycle(P_IDLE, 2'd0, "pre_cfg");
        idle_inputs();
        cfg_valid = 1'b1; frame_start = with_start;
        cfg_max_x = XW'(mx); cfg_max_y = YW'(my); cfg_sigma = 3'(sig); cfg_kernel_size = KW'(k);
        @(negedge clk);
        m_mx = XW'(mx); m_my = YW'(my); m_sig = 3'(sig); m_k = KW'(k);
        check_cycle(P_IDLE, 2'd0, with_start ? "cfg_with_start" : "cfg_load");
        idle_inputs();
    endtask

    task automatic run_frame(input string name, input int c, input int f, input int ta);
        int  t_term, t_err, ecode, p;
        bit  conv_ok, done_ok;
        s_legal = legal(int'(m_mx), int'(m_my), int'(m_k));
        s_c = c; s_f = f; s_ta = ta; s_clr_t = -1;
        s_abort_eff = (ta >= 0) && is_busy(raw_phase(ta));
        ecode = 0; t_err = -1;
        if (!s_legal) begin
            t_err = 1; ecode = 1;
        end else if (c > LIMIT) begin
            t_err = 2 + LIMIT; ecode = 2;
        end else if (f > LIMIT) begin
            t_err = 3 + c + LIMIT; ecode = 3;
        end
        if (s_abort_eff) t_term = ta + 1;
        else if (t_err >= 0) begin
            t_term = t_err; s_clr_t = t_err + 1;
        end else t_term = 4 + c + f;
        conv_ok = s_legal && (c <= LIMIT) && !(s_abort_eff && ta <= 1 + c);
        done_ok = s_legal && (c <= LIMIT) && (f <= LIMIT) && !s_abort_eff;
        for (int t = 0; t <= t_term + 3; t++) begin
            @(negedge clk);
`ifdef ISP_SEQ_PERF_CNT_EN
            if (conv_ok && t == 2 + c) m_cc = 32'(c);
`endif
            if (done_ok && t == 4 + c + f) begin
                m_count = m_count + 16'd1;
                m_buf   = ~m_buf;
            end
            p = phase(t);
            check_cycle(p, 2'(ecode), $sformatf("%s t=%0d", name, t));
            drive(t, p);
        end
        $display("frame %s legal=%0d c=%0d f=%0d ta=%0d conv_ok=%0d done=%0d count=%0d buf=%0d",
                 name, s_legal, c, f, ta, conv_ok, done_ok, m_count, m_buf);
    endtask

    initial begin
        int k, mx, my, c, f, ta;
        m_mx = '0; m_my = '0; m_sig = '0; m_k = '0;
        m_count = '0; m_buf = 1'b0; m_cc = '0;
        s_noise = 1'b0; s_c = 1000; s_f = 1000; s_ta = -1; s_clr_t = -1;
        idle_inputs();
        cfg_max_x = '0; cfg_max_y = '0; cfg_sigma = '0; cfg_kernel_size = '0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cycle(P_IDLE, 2'd0, "reset");
        n_rst = 1'b1;

        // Nominal frame with exact latencies
        load_cfg(9, 9, 2, 3, 1'b0);
        run_frame("nominal", 40, 10, -1);
        // Illegal kernel, abort and frame_start ignored while in ERROR
        load_cfg(9, 9, 2, 2, 1'b0);
        run_frame("bad_kernel", 5, 5, 2);
        load_cfg(0, 0, 1, 0, 1'b0);
        run_frame("kernel_zero", 5, 5, -1);
        load_cfg(1, 2, 1, 3, 1'b0);
        run_frame("x_too_small", 5, 5, -1);
        load_cfg(2, 1, 1, 3, 1'b0);
        run_frame("y_too_small", 5, 5, -1);
        load_cfg(0, 0, 5, 1, 1'b0);
        run_frame("k1_min_extent", 3, 3, -1);
        load_cfg(2, 2, 7, 3, 1'b1);
        run_frame("k3_min_extent", 3, 3, -1);
        // Watchdog boundaries
        run_frame("conv_timeout", 1000, 5, -1);
        run_frame("conv_done_at_limit", LIMIT, 4, -1);
        run_frame("fast_timeout", 7, 1000, -1);
        run_frame("fast_done_at_limit", 7, LIMIT, -1);
        // Abort collisions
        run_frame("abort_fast_wait_with_done", 10, 5, 17);
        run_frame("abort_with_conv_done", 20, 5, 21);
        run_frame("abort_at_conv_expiry", 1000, 5, 1 + LIMIT);
        run_frame("abort_in_done", 5, 5, 13);
        run_frame("abort_in_conv_start", 5, 5, 1);
        // Back-to-back frames with ignored noise on frame_start/cfg_valid
        s_noise = 1'b1;
        for (int i = 0; i < 3; i++) run_frame("back_to_back", 8 + i, 6, -1);

        for (int i = 0; i < 40; i++) begin
            k  = int'($urandom_range(0, 3));
            mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            my = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            load_cfg(mx, my, int'($urandom_range(0, 7)), k, $urandom_range(0, 7) == 0);
            c  = int'($urandom_range(1, 70));
            f  = int'($urandom_range(1, 70));
            ta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c + f + 4)) : -1;
            run_frame("random", c, f, ta);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/isp_frame_sequencer.md
Name: isp_frame_sequencer

Overview:
Frame-level controller for the ISP front end. Holds one validated configuration: image extent, Gaussian sigma and kernel size. On each frame request it starts the Gaussian convolution stage, waits for its completion, then starts the FAST corner stage and waits for that. It also owns the ping-pong output-bank select, a frame counter, watchdog timeouts, abort and error reporting.

Parameters:
X_MAX, 200, max image width; coordinate width XW = $clog2(X_MAX)
Y_MAX, 200, max image height; YW = $clog2(Y_MAX)
MAX_KERNEL, 3, largest legal odd kernel size; KW = $clog2(MAX_KERNEL)
TIMEOUT_W, 20, watchdog counter width; a stage times out after 2**TIMEOUT_W-1 wait cycles

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
cfg_valid  in  1  config offer
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_max_x  in  XW  last column index
cfg_max_y  in  YW  last row index
cfg_sigma  in  3  Gaussian sigma code
cfg_kernel_size  in  KW  kernel size
frame_start  in  1  start-frame pulse
abort  in  1  cancel current frame
err_clr  in  1  leave ERROR
busy  out  1  frame in flight
frame_done  out  1  one-cycle completion pulse
frame_err  out  1  high while in ERROR
err_code  out  2  0 none, 1 bad config, 2 conv timeout, 3 fast timeout
conv_new_trans  out  1  one-cycle start to the convolution stage
conv_done  in  1  convolution complete pulse
conv_max_x / conv_max_y  out  XW/YW  shadow extent, stable while busy
conv_sigma / conv_kernel_size  out  3/KW  shadow kernel params, stable while busy
fast_start  out  1  one-cycle start to the FAST stage
fast_done  in  1  FAST complete pulse
buf_sel  out  1  output bank for the current frame
frame_count  out  16  completed frames, wraps
conv_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset: state IDLE; shadow regs 0; all outputs 0 except cfg_ready=1.
- Moore FSM. Output pulses decode from state. States: IDLE, CONV_START, CONV_WAIT, FAST_START, FAST_WAIT, DONE, ERROR.
- cfg_ready=1 only in IDLE. A config handshake loads the shadow regs at that edge.
- Config is legal when all of these hold: kernel_size odd, 1 <= kernel_size <= MAX_KERNEL, max_x >= kernel_size-1, max_y >= kernel_size-1. Legality is evaluated on the shadow regs at frame_start.
- IDLE:
  - If cfg_valid and frame_start arrive in the same cycle, the config loads and frame_start is ignored.
  - frame_start with legal shadow -> CONV_START.
  - frame_start with illegal shadow -> ERROR, err_code=1.
- CONV_START: conv_new_trans=1 for exactly one cycle -> CONV_WAIT. Watchdog cleared.
- CONV_WAIT:
  - conv_done -> FAST_START.
  - Otherwise the watchdog increments. At all-ones -> ERROR, err_code=2.
  - conv_done in the same cycle as expiry: done wins.
- FAST_START: fast_start=1 for one cycle -> FAST_WAIT. Watchdog cleared.
- FAST_WAIT: fast_done -> DONE. Timeout -> ERROR, err_code=3. Done wins on collision.
- DONE: frame_done=1 for one cycle -> IDLE. On the DONE->IDLE edge, buf_sel toggles and frame_count increments (0xFFFF -> 0x0000).
- ERROR: frame_err=1, busy=0, cfg_ready=0. err_clr -> IDLE and err_code clears to 0. frame_count and buf_sel are unchanged.
- busy=1 in every state except IDLE and ERROR.
- abort in any busy state -> IDLE next edge. No frame_done; frame_count and buf_sel unchanged; no error. abort has priority over done/timeout in the same cycle. abort is ignored in IDLE and ERROR.
- frame_start while busy or in ERROR is ignored.
- conv_done/fast_done outside their wait state are ignored.
- Latency:
  - frame_start sampled at edge N -> conv_new_trans high in cycle N+1.
  - conv_done at edge M -> fast_start high in cycle M+1.
  - fast_done at edge K -> frame_done high in cycle K+1; buf_sel/frame_count update visible in cycle K+2.

Optional Feature:
ISP_SEQ_PERF_CNT_EN
- Defined: a 32-bit counter clears on entry to CONV_WAIT and increments each CONV_WAIT cycle, saturating at 0xFFFFFFFF. On conv_done it is copied to conv_cycles, which holds until the next completed convolution. Reset 0.
- Undefined: conv_cycles tied to 0 and no counter logic.

Test Plan:
- Config max_x=9, max_y=9, kernel 3, sigma 2; frame_start; conv_done 40 cycles later; fast_done 10 cycles later -> one pulse each of conv_new_trans, fast_start and frame_done at the specified latencies; frame_count=1, buf_sel=1.
- Config kernel_size=2, then frame_start -> ERROR, frame_err=1, err_code=1, no conv_new_trans. err_clr -> IDLE, err_code=0.
- TIMEOUT_W=4, frame_start, conv_done never arrives -> ERROR with err_code=2 after 15 CONV_WAIT cycles. Repeat with conv_done on cycle 15 -> FAST_START, no error.
- abort 5 cycles into FAST_WAIT, with fast_done in the same cycle -> IDLE, no frame_done, frame_count and buf_sel unchanged.
- Run 3 back-to-back frames; also pulse frame_start and cfg_valid mid-frame -> both ignored, cfg_ready=0, conv_* outputs stable. Ends with frame_count=3, buf_sel=1.
- With ISP_SEQ_PERF_CNT_EN: conv_done after 40 CONV_WAIT cycles -> conv_cycles=40. Without the macro -> conv_cycles=0.
